// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's instruction-memory, control-unit and status signals.
// master is the sequencer side; slave is the memory / control-unit / datapath side.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op_code;
    logic        instr_valid;
    logic        instr_ready;
    logic        res_valid;
    logic        jump;
    logic        beq;
    logic        alu_zero;
    logic [31:0] pc;
    logic [31:0] retired_cnt;
    logic        halted;

    modport master (
        output imem_req, imem_addr, instr, op_code, instr_valid, pc, retired_cnt, halted,
        input  imem_ack, imem_rdata, instr_ready, res_valid, jump, beq, alu_zero
    );

    modport slave (
        input  imem_req, imem_addr, instr, op_code, instr_valid, pc, retired_cnt, halted,
        output imem_ack, imem_rdata, instr_ready, res_valid, jump, beq, alu_zero
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle MIPS instruction-fetch sequencer: owns the PC, fetches, issues, and resolves one instruction at a time.
// Optional macro FETCH_HALT_EN adds a HALT state entered when opcode 6'b111111 resolves.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   S_IDLE    | after reset, one cycle before the first fetch
//   S_FETCH   | imem_req high, waiting for imem_ack
//   S_ISSUE   | instr_valid high, waiting for instr_ready
//   S_RESOLVE | waiting for res_valid, then PC update
//   S_HALT    | stopped until reset (FETCH_HALT_EN only)
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

`ifdef FETCH_HALT_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESOLVE, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESOLVE} state_t;
`endif

    state_t      state, state_next;
    logic        load_instr;
    logic        retire;
    logic        update_pc;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic        halted_q;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] pc_target;

    assign pc4    = pc_q + 32'd4;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // jump has priority over a taken branch; everything wraps modulo 2^32
    always_comb begin
        pc_target = pc4;
        if (bus.jump)
            pc_target = {pc4[31:28], instr_q[25:0], 2'b00};
        else if (bus.beq && bus.alu_zero)
            pc_target = pc4 + br_off;
    end

    always_comb begin
        state_next = state;
        load_instr = 1'b0;
        retire     = 1'b0;
        update_pc  = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ack) begin
                    load_instr = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.instr_ready)
                    state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (bus.res_valid) begin
                    retire = 1'b1;
`ifdef FETCH_HALT_EN
                    if (instr_q[31:26] == 6'b111111) begin
                        state_next = S_HALT;
                    end else begin
                        update_pc  = 1'b1;
                        state_next = S_FETCH;
                    end
`else
                    update_pc  = 1'b1;
                    state_next = S_FETCH;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            retired_q     <= 32'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state         <= state_next;
            imem_req_q    <= (state_next == S_FETCH);
            instr_valid_q <= (state_next == S_ISSUE);
`ifdef FETCH_HALT_EN
            halted_q      <= (state_next == S_HALT);
`else
            halted_q      <= 1'b0;
`endif
            if (load_instr)
                instr_q <= bus.imem_rdata;
            if (update_pc)
                pc_q <= pc_target;
            if (retire)
                retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.op_code     = instr_q[31:26];
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.retired_cnt = retired_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (RESET_PC = 32'h100); expected PCs are hand-computed.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] held;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Drives one full fetch/issue/resolve handshake; ok=0 if the sequencer never reaches a stage.
    task automatic do_instr(input logic [31:0] word, input logic j, input logic b,
                            input logic z, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !bus.imem_req; i++) @(negedge clk);
        if (!bus.imem_req) return;
        bus.imem_ack = 1'b1; bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        if (!bus.instr_valid) return;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.res_valid = 1'b1; bus.jump = j; bus.beq = b; bus.alu_zero = z;
        @(negedge clk);
        bus.res_valid = 1'b0; bus.jump = 1'b0; bus.beq = 1'b0; bus.alu_zero = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.instr_ready = 1'b0;
        bus.res_valid = 1'b0; bus.jump = 1'b0; bus.beq = 1'b0; bus.alu_zero = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req: got %b expected 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rst_imem_addr: got %h expected 00000100", bus.imem_addr); end
        checks++; if (bus.instr !== 32'd0) begin errors++; $display("FAIL rst_instr: got %h expected 0", bus.instr); end
        checks++; if (bus.op_code !== 6'd0) begin errors++; $display("FAIL rst_op_code: got %h expected 0", bus.op_code); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL rst_pc: got %h expected 00000100", bus.pc); end
        checks++; if (bus.retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_retired: got %0d expected 0", bus.retired_cnt); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b expected 0", bus.halted); end
    endtask

    // Zero-wait memory with ready/res_valid always high: 3 cycles per instruction.
    task automatic test_min_loop();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0020;
        bus.instr_ready = 1'b1; bus.res_valid = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1 || k == 4 || k == 7) begin
                checks++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 + 32'((k - 1) / 3 * 4)) begin
                    errors++;
                    $display("FAIL loop_fetch_c%0d: got req=%b addr=%h expected req=1 addr=%h",
                             k, bus.imem_req, bus.imem_addr, 32'h100 + 32'((k - 1) / 3 * 4));
                end
            end
            if (k == 2) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr !== 32'h20) begin
                    errors++;
                    $display("FAIL loop_issue: got valid=%b req=%b instr=%h expected 1 0 00000020",
                             bus.instr_valid, bus.imem_req, bus.instr);
                end
            end
        end
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.res_valid = 1'b0;
        checks++; if (bus.retired_cnt !== 32'd3) begin errors++; $display("FAIL loop_retired: got %0d expected 3", bus.retired_cnt); end
        checks++; if (bus.imem_addr !== 32'h10C) begin errors++; $display("FAIL loop_next_addr: got %h expected 0000010c", bus.imem_addr); end
        exp_pc = 32'h10C; exp_ret = 32'd3;
    endtask

    task automatic test_jump();
        bit ok;
        do_instr(32'h0810_0000, 1'b1, 1'b0, 1'b0, ok);
        exp_pc = 32'h0040_0000; exp_ret++;
        checks++; if (!ok || bus.pc !== exp_pc) begin errors++; $display("FAIL jump_to_400000: got ok=%b pc=%h expected pc=%h", ok, bus.pc, exp_pc); end
        do_instr(32'h0800_0010, 1'b1, 1'b0, 1'b0, ok);
        exp_pc = 32'h0000_0040; exp_ret++;
        checks++; if (!ok || bus.imem_addr !== exp_pc || bus.imem_req !== 1'b1) begin errors++; $display("FAIL jump_target: got ok=%b addr=%h req=%b expected addr=%h req=1", ok, bus.imem_addr, bus.imem_req, exp_pc); end
        checks++; if (bus.retired_cnt !== exp_ret) begin errors++; $display("FAIL jump_retired: got %0d expected %0d", bus.retired_cnt, exp_ret); end
    endtask

    task automatic test_beq();
        bit ok;
        do_instr(32'h0800_0080, 1'b1, 1'b0, 1'b0, ok);
        exp_pc = 32'h200; exp_ret++;
        checks++; if (!ok || bus.pc !== exp_pc) begin errors++; $display("FAIL beq_setup: got ok=%b pc=%h expected %h", ok, bus.pc, exp_pc); end
        do_instr(32'h1000_FFFF, 1'b0, 1'b1, 1'b1, ok);
        exp_pc = 32'h200; exp_ret++;
        checks++; if (!ok || bus.pc !== exp_pc) begin errors++; $display("FAIL beq_taken: got ok=%b pc=%h expected %h", ok, bus.pc, exp_pc); end
        do_instr(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, ok);
        exp_pc = 32'h204; exp_ret++;
        checks++; if (!ok || bus.pc !== exp_pc) begin errors++; $display("FAIL beq_not_taken: got ok=%b pc=%h expected %h", ok, bus.pc, exp_pc); end
    endtask

    task automatic test_jump_priority();
        bit ok;
        do_instr(32'h0800_0080, 1'b1, 1'b1, 1'b1, ok);
        exp_pc = 32'h200; exp_ret++;
        checks++; if (!ok || bus.pc !== exp_pc) begin errors++; $display("FAIL jump_over_beq: got ok=%b pc=%h expected %h", ok, bus.pc, exp_pc); end
        checks++; if (bus.retired_cnt !== exp_ret) begin errors++; $display("FAIL prio_retired: got %0d expected %0d", bus.retired_cnt, exp_ret); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_instr(32'h1000_FF7E, 1'b0, 1'b1, 1'b1, ok);
        exp_pc = 32'hFFFF_FFFC; exp_ret++;
        checks++; if (!ok || bus.pc !== exp_pc) begin errors++; $display("FAIL neg_branch_wrap: got ok=%b pc=%h expected %h", ok, bus.pc, exp_pc); end
        do_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0, ok);
        exp_pc = 32'h0; exp_ret++;
        checks++; if (!ok || bus.imem_addr !== exp_pc) begin errors++; $display("FAIL pc_wrap: got ok=%b addr=%h expected %h", ok, bus.imem_addr, exp_pc); end
    endtask

    task automatic test_stall();
        // Late ack, with res_valid/instr_ready asserted during FETCH where they must be ignored
        bus.res_valid = 1'b1; bus.instr_ready = 1'b1; bus.jump = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.pc !== exp_pc) begin
                errors++;
                $display("FAIL stall_fetch_c%0d: got req=%b valid=%b pc=%h expected 1 0 %h",
                         i, bus.imem_req, bus.instr_valid, bus.pc, exp_pc);
            end
        end
        bus.res_valid = 1'b0; bus.instr_ready = 1'b0; bus.jump = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2000_1234;
        @(negedge clk);
        bus.imem_rdata = 32'hFFFF_FFFF;
        held = 32'h2000_1234;
        checks++; if (bus.instr !== held || bus.op_code !== 6'h08 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_issue: got instr=%h op=%h valid=%b expected %h 08 1", bus.instr, bus.op_code, bus.instr_valid, held); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.instr !== held || bus.instr_valid !== 1'b1 || bus.pc !== exp_pc) begin
                errors++;
                $display("FAIL stall_hold_c%0d: got instr=%h valid=%b pc=%h expected %h 1 %h",
                         i, bus.instr, bus.instr_valid, bus.pc, held, exp_pc);
            end
        end
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b0 || bus.pc !== exp_pc || bus.instr !== held) begin errors++; $display("FAIL stall_resolve_wait: got valid=%b pc=%h instr=%h expected 0 %h %h", bus.instr_valid, bus.pc, bus.instr, exp_pc, held); end
        bus.res_valid = 1'b1;
        @(negedge clk);
        bus.res_valid = 1'b0;
        exp_pc = exp_pc + 32'd4; exp_ret++;
        checks++; if (bus.pc !== exp_pc || bus.retired_cnt !== exp_ret) begin errors++; $display("FAIL stall_resolved: got pc=%h ret=%0d expected %h %0d", bus.pc, bus.retired_cnt, exp_pc, exp_ret); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.pc !== 32'h100 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL midrst_async: got req=%b pc=%h addr=%h expected 0 00000100 00000100", bus.imem_req, bus.pc, bus.imem_addr); end
        checks++; if (bus.retired_cnt !== 32'd0 || bus.instr !== 32'd0 || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL midrst_regs: got ret=%0d instr=%h valid=%b halted=%b expected 0 0 0 0", bus.retired_cnt, bus.instr, bus.instr_valid, bus.halted); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.instr !== 32'd0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL late_ack_ignored: got req=%b instr=%h valid=%b expected 1 0 0", bus.imem_req, bus.instr, bus.instr_valid); end
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL late_ack_state: got req=%b valid=%b addr=%h expected 1 0 00000100", bus.imem_req, bus.instr_valid, bus.imem_addr); end
        exp_pc = 32'h100; exp_ret = 32'd0;
    endtask

    task automatic test_halt_opcode();
        bit ok;
        do_instr(32'hFC00_0000, 1'b0, 1'b0, 1'b0, ok);
        exp_ret++;
        checks++; if (!ok || bus.retired_cnt !== exp_ret) begin errors++; $display("FAIL halt_op_retired: got ok=%b ret=%0d expected %0d", ok, bus.retired_cnt, exp_ret); end
`ifdef FETCH_HALT_EN
        bus.imem_ack = 1'b1; bus.instr_ready = 1'b1; bus.res_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.pc !== exp_pc) begin
                errors++;
                $display("FAIL halt_state_c%0d: got halted=%b req=%b valid=%b pc=%h expected 1 0 0 %h",
                         i, bus.halted, bus.imem_req, bus.instr_valid, bus.pc, exp_pc);
            end
            @(negedge clk);
        end
        bus.imem_ack = 1'b0; bus.instr_ready = 1'b0; bus.res_valid = 1'b0;
        checks++; if (bus.retired_cnt !== exp_ret) begin errors++; $display("FAIL halt_retired_stable: got %0d expected %0d", bus.retired_cnt, exp_ret); end
`else
        exp_pc = exp_pc + 32'd4;
        checks++; if (bus.pc !== exp_pc || bus.halted !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL ff_opcode_plain: got pc=%h halted=%b req=%b expected %h 0 1", bus.pc, bus.halted, bus.imem_req, exp_pc); end
`endif
    endtask

    initial begin
        exp_pc = 32'h100;
        exp_ret = 32'd0;
        held = 32'd0;
        test_reset();
        test_min_loop();
        test_jump();
        test_beq();
        test_jump_priority();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_halt_opcode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the 32-bit MIPS core: it owns the program counter, fetches instructions from instruction memory, and presents each instruction's `op_code` to the control unit. It then consumes the control unit's `jump`/`beq` decisions, together with the datapath `alu_zero` flag, to choose the next PC. This is the producer side of the control-unit interface. Exactly one instruction is in flight at a time (multi-cycle, non-pipelined).

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `imem_req`  out  1  instruction memory read request.
- `imem_addr`  out  32  read address; equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word, sampled when `imem_req`&`imem_ack`.
- `instr`  out  32  registered current instruction.
- `op_code`  out  6  `instr[31:26]`, to control unit.
- `instr_valid`  out  1  `instr`/`op_code` valid for decode.
- `instr_ready`  in  1  decode/datapath accepts the instruction.
- `res_valid`  in  1  execution resolved; `jump`/`beq`/`alu_zero` valid.
- `jump`  in  1  from control unit.
- `beq`  in  1  from control unit.
- `alu_zero`  in  1  ALU zero flag from datapath.
- `pc`  out  32  address of the current instruction.
- `retired_cnt`  out  32  count of resolved instructions.
- `halted`  out  1  sequencer stopped (only when `FETCH_HALT_EN` is defined).

## Operation
- States: IDLE, FETCH, ISSUE, RESOLVE, HALT (HALT exists only with the macro).
- IDLE: entered on reset. Moves to FETCH on the first clock edge after `rst_n` deasserts.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack`=1: `instr`<=`imem_rdata`, go to ISSUE.
  - Otherwise wait indefinitely.
- ISSUE: `instr_valid`=1.
  - On `instr_valid`&`instr_ready`: go to RESOLVE.
  - `instr` is held stable until that transfer.
- RESOLVE: `instr_valid`=0. On `res_valid`=1:
  - Compute `pc4` = `pc`+4.
  - If `jump`=1: `pc` <= {`pc4`[31:28], `instr`[25:0], 2'b00}.
  - Else if `beq`&`alu_zero`: `pc` <= `pc4` + ({{14{`instr`[15]}}, `instr`[15:0]} << 2).
  - Else: `pc` <= `pc4`.
  - `retired_cnt` increments; go to FETCH.
- Priority: `jump` beats `beq`. `beq` with `alu_zero`=0 falls through to `pc4`.
- Arithmetic: all PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0. Negative branch offsets wrap the same way.
- `retired_cnt` wraps from 32'hFFFF_FFFF to 0.
- Signals ignored outside their own state, with no side effects:
  - `imem_ack` outside FETCH.
  - `instr_ready` outside ISSUE.
  - `res_valid` outside RESOLVE.
- Reset in any state, mid-operation: immediate return to IDLE. Any outstanding memory request is abandoned; a late `imem_ack` is ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr`=0, `op_code`=0, `instr_valid`=0.
  - `pc`=`RESET_PC`, `retired_cnt`=0, `halted`=0.
- `imem_req` and `instr_valid` are registered state decodes. They rise on the first cycle of their state.
- Minimum loop (zero-wait memory, `instr_ready` and `res_valid` high in the first cycle of their states): 3 cycles per instruction (FETCH, ISSUE, RESOLVE).
- `pc` and `retired_cnt` update on the RESOLVE exit edge. The new `imem_addr` is visible in the next FETCH cycle.
- `instr` changes only on the FETCH exit edge.

## Configuration
- Macro: `FETCH_HALT_EN`.
- Defined:
  - In RESOLVE with `res_valid`=1 and `op_code`=6'b111111: `retired_cnt` increments, `pc` is not updated, and the state goes to HALT.
  - HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. Only reset leaves HALT.
- Undefined:
  - No HALT state; `halted` is tied to 0.
  - Opcode 6'b111111 resolves like any other opcode (pc+4 unless `jump`/`beq`).

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory returning 32'h0000_0020 (op 000000), `res_valid`=1, no jump/beq → `imem_addr` sequence 100, 104, 108; 3 cycles each; `retired_cnt`=3 after 9 cycles.
- At `pc`=32'h0040_0000, instr 32'h0800_0010 (J), `jump`=1 → next `imem_addr`=32'h0000_0040.
- BEQ at `pc`=32'h200, instr 32'h1000_FFFF, `beq`=1:
  - `alu_zero`=1 → next `pc`=32'h200.
  - `alu_zero`=0 → next `pc`=32'h204.
- `jump`=1 and `beq`=1 with `alu_zero`=1 simultaneously → jump target taken.
- `imem_ack` delayed 4 cycles and `instr_ready` low 2 cycles → `instr` held stable, no `pc` change; `rst_n` pulsed low mid-FETCH → all outputs at reset values, and a late `imem_ack` is ignored.
- With `FETCH_HALT_EN`: instr 32'hFC00_0000 resolved → `halted`=1, `imem_req` stays 0, `retired_cnt` increments by 1. Without the macro, the same word gives `pc`+4.
